// File: rtl/poly_result_packer64.sv
// Drains the multiplier accumulator into 64-bit BRAM words: pass-through 4x16 or dense 13-bit packing.
// Optional macro PACKER_ROUND_EN: packed coefficients become ((c + H1) mod 2^13) >> 3 (10 bits).
module poly_result_packer64 #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned H1     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_coeff4x,
    input  logic [63:0]       coeff4x_in,
    output logic              read,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [63:0]       bram_din,
    output logic              busy,
    output logic              done
);

`ifdef PACKER_ROUND_EN
    localparam int unsigned CW = 10;
`else
    localparam int unsigned CW = 13;
`endif
    localparam int unsigned PW = 4 * CW;
    localparam int unsigned SW = 116;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q;
    logic [5:0]          rd_cnt;
    logic [5:0]          fill_q;
    logic [SW-1:0]       stage_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                accept;

    logic [PW-1:0]       pk;
    logic [SW-1:0]       combined;
    logic [6:0]          cnt_sum;
    logic                emit;

    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  if (rd_cnt == 6'd63) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (start) state_d = S_READ;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        read = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_READ:  begin read = 1'b1; busy = 1'b1; end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pk = '0;
        for (int unsigned i = 0; i < 4; i++) begin
`ifdef PACKER_ROUND_EN
            pk[CW*i +: CW] = 10'(13'(coeff4x_in[16*i +: 13] + 13'(H1)) >> 3);
`else
            pk[CW*i +: CW] = coeff4x_in[16*i +: 13];
`endif
        end
    end

`ifndef PACKER_ROUND_EN
    logic unused_h1;
    assign unused_h1 = ^13'(H1);
`endif

    // New coefficients land directly above the bits already staged.
    assign combined = stage_q | (SW'(pk) << fill_q);
    assign cnt_sum  = {1'b0, fill_q} + 7'(PW);
    assign emit     = (cnt_sum >= 7'd64);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= 1'b0;
            rd_cnt    <= '0;
            fill_q    <= '0;
            stage_q   <= '0;
            addr_q    <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else if (accept) begin
            mode_q    <= mode_coeff4x;
            rd_cnt    <= '0;
            fill_q    <= '0;
            stage_q   <= '0;
            addr_q    <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
        end else if (state_q == S_READ) begin
            rd_cnt <= rd_cnt + 6'd1;
            if (mode_q) begin
                bram_we   <= 1'b1;
                bram_din  <= coeff4x_in;
                bram_addr <= addr_q;
                addr_q    <= addr_q + ADDR_W'(1);
            end else if (emit) begin
                bram_we   <= 1'b1;
                bram_din  <= combined[63:0];
                bram_addr <= addr_q;
                addr_q    <= addr_q + ADDR_W'(1);
                stage_q   <= combined >> 64;
                fill_q    <= 6'(cnt_sum - 7'd64);
            end else begin
                bram_we   <= 1'b0;
                stage_q   <= combined;
                fill_q    <= cnt_sum[5:0];
            end
        end else begin
            bram_we <= 1'b0;
        end
    end

endmodule
